// File: rtl/step_input_ctrl.sv
// Front-panel input conditioner: synchronises and debounces the step and display-select buttons,
// issues one CPU step pulse per accepted press, latches the switches and counts steps.
module step_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             CCLK,
    input  logic             rst_n,
    input  logic             BTN2,
    input  logic             BTN1,
    input  logic [3:0]       SW,
    output logic             step_pulse,
    output logic             disp_sel,
    output logic [3:0]       sw_latched,
    output logic [CNT_W-1:0] step_count
);

    localparam logic [7:0] DebLast = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        StArm,
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } step_state_e;

    logic [1:0]       btn2_sync_q;
    logic [1:0]       btn1_sync_q;
    logic [3:0]       sw_s1_q;
    logic [3:0]       sw_s2_q;
    logic             btn2_s2;
    logic             btn1_s2;

    step_state_e      state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             pulse_d;

    logic             step_pulse_q;
    logic [3:0]       sw_latched_q;
    logic [CNT_W-1:0] step_count_q;
    logic             disp_sel_q;
    logic [7:0]       disp_cnt_q;

    assign btn2_s2 = btn2_sync_q[1];
    assign btn1_s2 = btn1_sync_q[1];

    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            btn2_sync_q <= '0;
            btn1_sync_q <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
        end else begin
            btn2_sync_q <= {btn2_sync_q[0], BTN2};
            btn1_sync_q <= {btn1_sync_q[0], BTN1};
            sw_s1_q     <= SW;
            sw_s2_q     <= sw_s1_q;
        end
    end

    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StArm;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ARM waits for a released button so a press held through reset never steps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            StArm: begin
                if (btn2_s2) begin
                    cnt_d = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StIdle: begin
                if (btn2_s2) begin
                    state_d = StPressWait;
                    cnt_d   = 8'd1;
                end
            end
            StPressWait: begin
                if (!btn2_s2) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StPressed: begin
                if (!btn2_s2) begin
                    state_d = StReleaseWait;
                    cnt_d   = 8'd1;
                end
            end
            StReleaseWait: begin
                if (btn2_s2) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StArm;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            step_pulse_q <= 1'b0;
            sw_latched_q <= '0;
            step_count_q <= '0;
        end else begin
            step_pulse_q <= pulse_d;
            if (pulse_d) begin
                sw_latched_q <= sw_s2_q;
                step_count_q <= step_count_q + CNT_W'(1);
            end
        end
    end

    // Level filter: flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            disp_sel_q <= 1'b0;
            disp_cnt_q <= '0;
        end else if (btn1_s2 != disp_sel_q) begin
            if (disp_cnt_q == DebLast) begin
                disp_sel_q <= btn1_s2;
                disp_cnt_q <= '0;
            end else begin
                disp_cnt_q <= disp_cnt_q + 8'd1;
            end
        end else begin
            disp_cnt_q <= '0;
        end
    end

    assign step_pulse = step_pulse_q;
    assign sw_latched = sw_latched_q;
    assign step_count = step_count_q;
    assign disp_sel   = disp_sel_q;

endmodule

// File: tb/tb_step_input_ctrl.sv
// Scoreboard bench for step_input_ctrl: stimulus pushes expected pulses, a monitor pops and checks.
module tb_step_input_ctrl;

    localparam int D = 4;

    logic        CCLK;
    logic        rst_n;
    logic        BTN2;
    logic        BTN1;
    logic [3:0]  SW;
    logic        step_pulse;
    logic        disp_sel;
    logic [3:0]  sw_latched;
    logic [15:0] step_count;

    logic        step_pulse_w;
    logic        disp_sel_w;
    logic [3:0]  sw_latched_w;
    logic [2:0]  step_count_w;

    step_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .CCLK       (CCLK),
        .rst_n      (rst_n),
        .BTN2       (BTN2),
        .BTN1       (BTN1),
        .SW         (SW),
        .step_pulse (step_pulse),
        .disp_sel   (disp_sel),
        .sw_latched (sw_latched),
        .step_count (step_count)
    );

    // Narrow counter copy so wrap-around is reachable in a few presses.
    step_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut_wrap (
        .CCLK       (CCLK),
        .rst_n      (rst_n),
        .BTN2       (BTN2),
        .BTN1       (BTN1),
        .SW         (SW),
        .step_pulse (step_pulse_w),
        .disp_sel   (disp_sel_w),
        .sw_latched (sw_latched_w),
        .step_count (step_count_w)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  sw;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc;
    int          n_checks;
    int          n_pass;
    logic [15:0] exp_count;
    logic        prev_pulse;

    initial CCLK = 1'b0;
    always #1 CCLK = ~CCLK;

    always @(posedge CCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: sample on the falling edge, compare every pulse against the scoreboard.
    always @(negedge CCLK) begin
        if (rst_n && step_pulse) begin
            if (prev_pulse) check("pulse_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(cyc), 32'hffff_ffff);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("sw_latched", 32'(sw_latched), 32'(e.sw));
                check("step_count", 32'(step_count), 32'(e.cnt));
                check("step_count_wrap", 32'(step_count_w), 32'(e.cnt[2:0]));
            end
        end
        prev_pulse = step_pulse;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CCLK);
    endtask

    // Clean press of n samples that is expected to produce one pulse.
    task automatic press(input int n, input logic [3:0] sw);
        exp_t e;
        @(negedge CCLK);
        exp_count = exp_count + 16'd1;
        e.cyc = cyc + 1 + D + 1;
        e.sw  = sw;
        e.cnt = exp_count;
        exp_q.push_back(e);
        BTN2 = 1'b1;
        idle(n);
        BTN2 = 1'b0;
        idle(12);
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        cyc = 0; n_checks = 0; n_pass = 0; exp_count = '0; prev_pulse = 1'b0;
        rst_n = 1'b0; BTN2 = 1'b0; BTN1 = 1'b0; SW = 4'h0;
        idle(3);
        check("rst_step_pulse", 32'(step_pulse), 32'd0);
        check("rst_disp_sel", 32'(disp_sel), 32'd0);
        check("rst_sw_latched", 32'(sw_latched), 32'd0);
        check("rst_step_count", 32'(step_count), 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Five-sample press: one pulse at E0+D+1.
        press(5, 4'h0);
        check("count_after_first", 32'(step_count), 32'd1);

        // Three-sample press is too short.
        BTN2 = 1'b1; idle(3); BTN2 = 1'b0; idle(12);
        check("short_press_count", 32'(step_count), 32'd1);

        SW = 4'b0011; idle(4);
        press(5, 4'h3);
        check("sw_after_2nd", 32'(sw_latched), 32'h3);
        SW = 4'b0101; idle(4);
        press(5, 4'h5);
        check("sw_after_3rd", 32'(sw_latched), 32'h5);
        check("count_after_3rd", 32'(step_count), 32'd3);

        // Bounce low one sample after two high samples; the debounce restarts at the re-rise.
        @(negedge CCLK);
        exp_count = exp_count + 16'd1;
        e.cyc = cyc + 1 + 3 + D + 1;
        e.sw  = 4'h5;
        e.cnt = exp_count;
        exp_q.push_back(e);
        BTN2 = 1'b1; idle(2);
        BTN2 = 1'b0; idle(1);
        BTN2 = 1'b1; idle(200);
        BTN2 = 1'b0; idle(12);
        check("bounce_drained", 32'(exp_q.size()), 32'd0);
        check("count_after_bounce", 32'(step_count), 32'd4);

        // disp_sel: 3 samples ignored, 5 samples accepted, then release follows.
        BTN1 = 1'b1; idle(3); BTN1 = 1'b0; idle(8);
        check("disp_short", 32'(disp_sel), 32'd0);
        BTN1 = 1'b1; idle(5); BTN1 = 1'b0; idle(2);
        check("disp_set", 32'(disp_sel), 32'd1);
        idle(10);
        check("disp_clear", 32'(disp_sel), 32'd0);
        check("disp_no_step", 32'(step_count), 32'd4);

        // Reset during a held press; no pulse until the button is released and pressed again.
        BTN2 = 1'b1; idle(2);
        rst_n = 1'b0; idle(3);
        check("midrst_count", 32'(step_count), 32'd0);
        check("midrst_sw", 32'(sw_latched), 32'd0);
        exp_count = '0;
        rst_n = 1'b1; idle(20);
        check("held_after_rst", 32'(step_count), 32'd0);
        BTN2 = 1'b0; idle(12);
        press(5, 4'h5);
        check("repress_count", 32'(step_count), 32'd1);

        // Eight more presses wrap the 3-bit counter past 7.
        for (int i = 0; i < 8; i++) begin
            SW = 4'(i + 8); idle(4);
            press(6, 4'(i + 8));
        end
        check("final_count", 32'(step_count), 32'd9);
        check("final_wrap_count", 32'(step_count_w), 32'd1);
        check("final_sw", 32'(sw_latched), 32'hf);

        idle(20);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
